// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common-data-bus arbiter with one-entry hold buffer per result source
module cdb_arbiter #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*TAG_W-1:0]  src_tag,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data
);

  localparam int PTR_W = $clog2(N_SRC);

  logic [N_SRC-1:0]  r_hold_valid;
  logic [TAG_W-1:0]  r_hold_tag  [N_SRC];
  logic [DATA_W-1:0] r_hold_data [N_SRC];
  logic [PTR_W-1:0]  r_rr_ptr;
  logic              r_cdb_valid;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_data;

  logic [N_SRC-1:0]  w_grant;
  logic              w_any;
  logic [PTR_W-1:0]  w_win;
  logic [PTR_W:0]    w_sum;
  logic [PTR_W-1:0]  w_idx;
  logic [PTR_W:0]    w_next_sum;
  logic [PTR_W-1:0]  w_next_ptr;
  logic [N_SRC-1:0]  w_xfer;

  // Round-robin search over held entries starting at rr_ptr, wrapping modulo N_SRC.
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(N_SRC)) begin
        w_sum = w_sum - (PTR_W+1)'(N_SRC);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!w_any && r_hold_valid[w_idx]) begin
        w_any          = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_win          = w_idx;
      end
    end
    w_next_sum = {1'b0, w_win} + (PTR_W+1)'(1);
    if (w_next_sum >= (PTR_W+1)'(N_SRC)) begin
      w_next_sum = w_next_sum - (PTR_W+1)'(N_SRC);
    end
    w_next_ptr = w_next_sum[PTR_W-1:0];
  end

  // Ready depends only on registered state and flush; a granted buffer can accept in the same cycle.
  always_comb begin
    src_ready = {N_SRC{~flush}} & (~r_hold_valid | w_grant);
    w_xfer    = src_valid & src_ready;
  end

  // Hold buffers, round-robin pointer and registered CDB broadcast.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_valid <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        r_hold_tag[i]  <= '0;
        r_hold_data[i] <= '0;
      end
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
    end else if (flush) begin
      r_hold_valid <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb_tag    <= '0;
      r_cdb_data   <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (w_xfer[i] && (src_tag[i*TAG_W +: TAG_W] != '0)) begin
          r_hold_valid[i] <= 1'b1;
          r_hold_tag[i]   <= src_tag[i*TAG_W +: TAG_W];
          r_hold_data[i]  <= src_data[i*DATA_W +: DATA_W];
        end else if (w_grant[i]) begin
          r_hold_valid[i] <= 1'b0;
        end
      end
      if (w_any) begin
        r_cdb_valid <= 1'b1;
        r_cdb_tag   <= r_hold_tag[w_win];
        r_cdb_data  <= r_hold_data[w_win];
        r_rr_ptr    <= w_next_ptr;
      end else begin
        r_cdb_valid <= 1'b0;
        r_cdb_tag   <= '0;
        r_cdb_data  <= '0;
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_data  = r_cdb_data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

  localparam int N_SRC  = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    flush;
  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC*TAG_W-1:0]  src_tag;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;

  int n_cmp;
  int n_err;

  cdb_arbiter #(.N_SRC(N_SRC), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_ready (src_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic offer(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    src_valid[i] = 1'b1;
    src_tag[i*TAG_W +: TAG_W] = t;
    src_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic check_cdb(input string name, input logic v, input logic [TAG_W-1:0] t,
                           input logic [DATA_W-1:0] d);
    check({name, "_valid"}, 64'(cdb_valid), 64'(v));
    check({name, "_tag"},   64'(cdb_tag),   64'(t));
    check({name, "_data"},  64'(cdb_data),  64'(d));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    flush     = 1'b0;
    src_valid = '0;
    src_tag   = '0;
    src_data  = '0;

    // reset state
    do_reset();
    settle();
    check_cdb("rst_cdb", 1'b0, 4'h0, 32'h0);
    check("rst_ptr", 64'(dut.r_rr_ptr), 64'd0);
    check("rst_ready", 64'(src_ready), 64'hF);

    // single offer from source 2
    offer(2, 4'd5, 32'h0000_00AA);
    settle();
    check("t1_ready2", 64'(src_ready[2]), 64'd1);
    tick();
    src_valid = '0;
    check_cdb("t1_pre", 1'b0, 4'h0, 32'h0);
    tick();
    check_cdb("t1_bcast", 1'b1, 4'd5, 32'hAA);
    tick();
    check_cdb("t1_idle", 1'b0, 4'h0, 32'h0);
    check("t1_ptr", 64'(dut.r_rr_ptr), 64'd3);

    // all four sources at once from rr_ptr 0; source 3 keeps offering a second result
    do_reset();
    for (int i = 0; i < N_SRC; i++) offer(i, 4'(i + 1), 32'((i + 1) * 16));
    tick();
    src_valid = 4'b1000;
    offer(3, 4'hC, 32'hC0);
    settle();
    check("t2_ready3_a", 64'(src_ready[3]), 64'd0);
    tick();
    check_cdb("t2_g1", 1'b1, 4'd1, 32'h10);
    check("t2_ready3_b", 64'(src_ready[3]), 64'd0);
    tick();
    check_cdb("t2_g2", 1'b1, 4'd2, 32'h20);
    check("t2_ready3_c", 64'(src_ready[3]), 64'd0);
    tick();
    check_cdb("t2_g3", 1'b1, 4'd3, 32'h30);
    check("t2_ready3_d", 64'(src_ready[3]), 64'd1);
    tick();
    src_valid = '0;
    check_cdb("t2_g4", 1'b1, 4'd4, 32'h40);
    tick();
    check_cdb("t2_g5", 1'b1, 4'hC, 32'hC0);
    tick();
    check_cdb("t2_idle", 1'b0, 4'h0, 32'h0);
    check("t2_ptr", 64'(dut.r_rr_ptr), 64'd0);

    // source 1 streams tags 6..9 back to back
    for (int i = 0; i < 4; i++) begin
      offer(1, 4'(6 + i), 32'(8'h66 + i));
      settle();
      check($sformatf("t3_ready1_%0d", i), 64'(src_ready[1]), 64'd1);
      tick();
      if (i > 0) check_cdb($sformatf("t3_cdb_%0d", i), 1'b1, 4'(5 + i), 32'(8'h66 + i - 1));
    end
    src_valid = '0;
    tick();
    check_cdb("t3_cdb_last", 1'b1, 4'd9, 32'h69);
    tick();
    check_cdb("t3_idle", 1'b0, 4'h0, 32'h0);
    check("t3_ptr", 64'(dut.r_rr_ptr), 64'd2);

    // move rr_ptr to 3 via one result from source 2
    offer(2, 4'd1, 32'h1);
    tick();
    src_valid = '0;
    tick();
    tick();
    check("t4_ptr0", 64'(dut.r_rr_ptr), 64'd3);

    // sources 0 and 3 continuously loaded: grants alternate 3,0,3,0
    offer(0, 4'hA, 32'hA0);
    offer(3, 4'hB, 32'hB0);
    tick();
    tick();
    check_cdb("t4_g0", 1'b1, 4'hB, 32'hB0);
    check("t4_p0", 64'(dut.r_rr_ptr), 64'd0);
    tick();
    check_cdb("t4_g1", 1'b1, 4'hA, 32'hA0);
    check("t4_p1", 64'(dut.r_rr_ptr), 64'd1);
    tick();
    check_cdb("t4_g2", 1'b1, 4'hB, 32'hB0);
    check("t4_p2", 64'(dut.r_rr_ptr), 64'd0);
    tick();
    check_cdb("t4_g3", 1'b1, 4'hA, 32'hA0);
    check("t4_p3", 64'(dut.r_rr_ptr), 64'd1);
    src_valid = '0;
    tick();
    tick();
    tick();
    check_cdb("t4_idle", 1'b0, 4'h0, 32'h0);
    check("t4_ptr_end", 64'(dut.r_rr_ptr), 64'd1);

    // tag 0 offer is consumed and never broadcast
    offer(0, 4'h0, 32'hDEAD);
    settle();
    check("t5_ready0", 64'(src_ready[0]), 64'd1);
    tick();
    src_valid = '0;
    check("t5_hold0", 64'(dut.r_hold_valid[0]), 64'd0);
    check_cdb("t5_cdb_a", 1'b0, 4'h0, 32'h0);
    tick();
    check_cdb("t5_cdb_b", 1'b0, 4'h0, 32'h0);
    tick();
    check_cdb("t5_cdb_c", 1'b0, 4'h0, 32'h0);

    // flush with three entries held and source 2 offering during flush
    offer(0, 4'd1, 32'h11);
    offer(1, 4'd2, 32'h22);
    offer(3, 4'd3, 32'h33);
    tick();
    src_valid = '0;
    flush = 1'b1;
    offer(2, 4'd7, 32'h77);
    settle();
    check("t6_ready_flush", 64'(src_ready), 64'h0);
    tick();
    flush = 1'b0;
    check_cdb("t6_after_flush", 1'b0, 4'h0, 32'h0);
    check("t6_hold", 64'(dut.r_hold_valid), 64'h0);
    check("t6_ptr", 64'(dut.r_rr_ptr), 64'd1);
    settle();
    check("t6_ready2", 64'(src_ready[2]), 64'd1);
    tick();
    src_valid = '0;
    check_cdb("t6_xfer", 1'b0, 4'h0, 32'h0);
    tick();
    check_cdb("t6_bcast", 1'b1, 4'd7, 32'h77);
    tick();
    check_cdb("t6_idle", 1'b0, 4'h0, 32'h0);
    check("t6_ptr_end", 64'(dut.r_rr_ptr), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter for the Tomasulo back end. It sits directly downstream of the reservation stations and their functional units (add/sub, mul/div). Each source delivers a finished result as a tag plus data. The block buffers one result per source, picks one per cycle by round-robin, and broadcasts it on the CDB. Waiting reservation stations and the register file snoop the CDB to match their Qj/Qk tags and capture the value.

## Interface
- N_SRC, 4, number of result sources (2..8)
- DATA_W, 32, result data width
- TAG_W, 4, tag width; tag 0 is reserved and means "value ready / no producer"
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- flush  input  1  synchronous squash of all buffered and broadcast results
- src_valid  input  N_SRC  per-source result offer
- src_tag  input  N_SRC*TAG_W  per-source tag; source i occupies bits [i*TAG_W +: TAG_W]
- src_data  input  N_SRC*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W]
- src_ready  output  N_SRC  per-source accept; combinational
- cdb_valid  output  1  broadcast valid (registered)
- cdb_tag  output  TAG_W  broadcast tag (registered)
- cdb_data  output  DATA_W  broadcast data (registered)

## Operation
- Per source i there is a one-entry hold buffer: hold_valid[i], hold_tag[i], hold_data[i].
- src_ready[i] = ~flush & (~hold_valid[i] | grant[i]).
- A transfer for source i occurs when src_valid[i] & src_ready[i].
  - On transfer with src_tag != 0: load the hold buffer with the tag and data.
  - On transfer with src_tag == 0: consume and discard the offer; the hold buffer is not loaded.
- Arbitration is combinational over the registered hold_valid and rr_ptr (width ceil(log2 N_SRC)).
  - Winner = first i with hold_valid[i], searching i = rr_ptr, rr_ptr+1, ..., wrapping modulo N_SRC.
  - grant is one-hot, or all zero if no hold entry is valid.
- On each edge when a grant exists and flush is low:
  - cdb_valid <= 1; cdb_tag and cdb_data <= the winner's hold_tag and hold_data.
  - hold_valid[winner] clears, unless the same source transfers in the same cycle; in that case the buffer reloads with the new result.
  - rr_ptr <= (winner + 1) mod N_SRC.
- On each edge when no grant exists and flush is low: cdb_valid <= 0, cdb_tag <= 0, cdb_data <= 0, rr_ptr unchanged.
- Idle CDB always shows tag 0 and data 0, so snoopers never see a false match.
- flush high at an edge:
  - all hold_valid <= 0; cdb_valid, cdb_tag, cdb_data <= 0; rr_ptr unchanged.
  - No transfer occurs that cycle, because src_ready is forced low.
- Reset (rst_n low at an edge), which overrides flush:
  - hold_valid all 0, hold_tag/hold_data 0, rr_ptr 0.
  - cdb_valid 0, cdb_tag 0, cdb_data 0.
  - src_ready reads all 1 after reset unless flush is high.
- Sources must hold src_valid, src_tag and src_data stable until a transfer occurs. The block does not check this.

## Timing
- Latency: offer transferred at edge k -> entry held after k -> earliest broadcast registered at edge k+1, so cdb_valid is visible in the cycle after k+1.
- Throughput: 1 broadcast per cycle total. A single uncontended source sustains 1 result per cycle, because ready bypasses on grant.
- Fairness: with M sources continuously holding results, each is granted exactly once every M cycles.
- No combinational path from src_* to cdb_*.
- The src_valid -> src_ready path does not exist; ready depends only on registered state and flush.

## Test plan
- Reset, then offer source 2 with tag 5, data 0x0000_00AA for one cycle:
  - src_ready[2] = 1 at the offer.
  - One cycle later cdb_valid = 1, cdb_tag = 5, cdb_data = 0xAA.
  - The following cycle cdb_valid = 0, tag 0, data 0.
- All 4 sources offer at once (tags 1..4, data 0x10..0x40) with rr_ptr = 0:
  - CDB order is tags 1, 2, 3, 4 on consecutive cycles.
  - src_ready[3] stays 0 until source 3's earlier entry is granted.
- Source 1 streams tags 6, 7, 8, 9 every cycle while the others are idle:
  - src_ready[1] stays 1 throughout.
  - CDB shows 6, 7, 8, 9 back-to-back with no bubble.
- Sources 0 and 3 both continuously loaded, starting with rr_ptr = 3:
  - Grants alternate 3, 0, 3, 0.
  - rr_ptr after each grant is 0, 1, 0, 1.
- Source 0 offers tag 0, data 0xDEAD:
  - src_ready[0] = 1 and the offer is consumed.
  - cdb_valid never rises and hold_valid[0] stays 0.
- Three entries held and flush pulsed for 1 cycle, with source 2 offering during flush:
  - After the edge, cdb_valid = 0 and all hold entries are empty.
  - src_ready = 0 during flush; source 2's offer transfers in the cycle after flush.
  - rr_ptr is unchanged.
